// File: rtl/trace_frame_ctrl.sv
// trace_frame_ctrl: assembles 8-word trace frames from a trace interface into
// a 16-word (two-frame) circular buffer, exposing only committed frames on a
// valid/ready read port.
// Optional build macro: TRACE_FRAME_STATS_EN enables the saturating
// frameCount / dropCount statistics; without it both outputs are tied to zero.
module trace_frame_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        WdAvail,
    input  logic [15:0] PacketWd,
    input  logic        PacketReset,
    input  logic        sync,
    input  logic [1:0]  cfgWidth,
    output logic [1:0]  width,
    output logic [15:0] FrWord,
    output logic        FrValid,
    input  logic        FrReady,
    output logic        FrLast,
    output logic        inSync,
    output logic [15:0] frameCount,
    output logic [15:0] dropCount
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        WAIT    = 2'd1,
        FILL    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic [4:0]  wp, wp_n;
    logic [4:0]  cp, cp_n;
    logic [4:0]  rp, rp_n;
    logic [1:0]  width_n;
    logic [4:0]  free;
    logic        we;
    logic        pop;
    logic [15:0] mem [16];

`ifdef TRACE_FRAME_STATS_EN
    logic        frame_inc;
    logic        drop_inc;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    // Free space counts uncommitted words too; at a frame start wp==cp, so a
    // frame is only admitted when all 8 of its words are guaranteed to fit,
    // which is what keeps the buffer from ever being written while full.
    assign free    = 5'd16 - (wp - rp);
    assign FrValid = (cp != rp);
    assign pop     = FrValid && FrReady;
    assign FrWord  = FrValid ? mem[rp[3:0]] : '0;
    assign FrLast  = FrValid && (rp[2:0] == 3'd7);
    assign inSync  = (state != HUNT);

    // Next-state, pointer and width decisions for the frame assembler.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        wp_n    = wp;
        cp_n    = cp;
        width_n = width;
        we      = 1'b0;
        rp_n    = rp + {4'd0, pop};
`ifdef TRACE_FRAME_STATS_EN
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
`endif
        case (state)
            HUNT: begin
                width_n = cfgWidth;
                if (sync) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (!sync) begin
                    state_n = HUNT;
                    idx_n   = '0;
                end else if (PacketReset) begin
                    state_n = FILL;
                    idx_n   = '0;
                end
            end
            FILL, DISCARD: begin
                if (!sync) begin
                    state_n = HUNT;
                    wp_n    = cp;
                    idx_n   = '0;
                end else if (PacketReset) begin
                    state_n = FILL;
                    wp_n    = cp;
                    idx_n   = '0;
                end else if (WdAvail) begin
                    if (state == DISCARD) begin
                        if (idx == 3'd7) begin
                            state_n = FILL;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else if ((idx == 3'd0) && (free < 5'd8)) begin
                        state_n = DISCARD;
                        idx_n   = 3'd1;
`ifdef TRACE_FRAME_STATS_EN
                        drop_inc = 1'b1;
`endif
                    end else begin
                        we    = 1'b1;
                        wp_n  = wp + 5'd1;
                        idx_n = idx + 3'd1;
                        if (idx == 3'd7) begin
                            cp_n  = wp + 5'd1;
                            idx_n = '0;
`ifdef TRACE_FRAME_STATS_EN
                            frame_inc = 1'b1;
`endif
                        end
                    end
                end
            end
            default: begin
                state_n = HUNT;
                idx_n   = '0;
            end
        endcase
    end

    // State, pointer and width registers; reset discards all buffered data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            idx   <= '0;
            wp    <= '0;
            cp    <= '0;
            rp    <= '0;
            width <= cfgWidth;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            wp    <= wp_n;
            cp    <= cp_n;
            rp    <= rp_n;
            width <= width_n;
        end
    end

    // Frame word storage; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[wp[3:0]] <= PacketWd;
        end
    end

`ifdef TRACE_FRAME_STATS_EN
    // Saturating committed-frame and dropped-frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_inc && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop_inc && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign frameCount = frame_cnt;
    assign dropCount  = drop_cnt;
`else
    assign frameCount = '0;
    assign dropCount  = '0;
`endif

endmodule

// File: doc/trace_frame_ctrl.md
TRACE_FRAME_CTRL -- requirements
Module: trace_frame_ctrl

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 WdAvail  input  1  one-cycle strobe, PacketWd valid, from trace interface.
REQ-004 PacketWd  input  16  received trace word.
REQ-005 PacketReset  input  1  one-cycle strobe, frame boundary (sync seen).
REQ-006 sync  input  1  trace interface in sync.
REQ-007 cfgWidth  input  2  requested trace bus width code (0,1=1 bit, 2=2 bit, 3=4 bit).
REQ-008 width  output  2  width code driven to trace interface.
REQ-009 FrWord  output  16  output word, head of committed data.
REQ-010 FrValid  output  1  FrWord valid.
REQ-011 FrReady  input  1  downstream accepts FrWord when FrValid&FrReady.
REQ-012 FrLast  output  1  FrWord is word 7 of its frame.
REQ-013 inSync  output  1  controller is not in HUNT.
REQ-014 frameCount  output  16  committed frames, saturating (see REQ-034).
REQ-015 dropCount  output  16  frames discarded for lack of space, saturating (see REQ-034).

Function
REQ-016 Frame = 8 consecutive PacketWd words; buffer = 16-word circular store (2 frames), write ptr wp, commit ptr cp, read ptr rp, each 5 bits (4 index + wrap).
REQ-017 States: HUNT, WAIT, FILL, DISCARD; word index idx 0..7.
REQ-018 HUNT: width<=cfgWidth every cycle; WdAvail ignored; sync=1 -> WAIT.
REQ-019 WAIT: words ignored; PacketReset -> FILL with idx=0.
REQ-020 FILL, idx=0 word: free=16-(wp-rp); free>=8 -> store at wp, wp+1, idx=1; free<8 -> DISCARD, idx=1, dropCount+1.
REQ-021 FILL, idx 1..7 word: store at wp, wp+1, idx+1; idx=7 word -> cp<=wp+1 same cycle, frameCount+1, idx=0, stay FILL.
REQ-022 DISCARD: words counted, not stored; 8th word -> FILL, idx=0.
REQ-023 PacketReset in FILL/DISCARD: wp<=cp (partial frame abandoned), idx=0, -> FILL; a WdAvail in the same cycle is discarded.
REQ-024 sync=0 in WAIT/FILL/DISCARD: wp<=cp, idx=0, -> HUNT; takes precedence over PacketReset and WdAvail.
REQ-025 Committed words = cp-rp; FrValid=(cp!=rp); FrWord=mem[rp]; FrLast=(rp[2:0]==7); combinational from registers, zero latency.
REQ-026 FrValid&FrReady -> rp+1; pop and commit in the same cycle both take effect.
REQ-027 Read side never sees uncommitted words; FrValid is not withdrawn until the word is accepted.
REQ-028 width changes only in HUNT; cfgWidth changes elsewhere have no effect until next HUNT.
REQ-029 Pointer arithmetic modulo 32; full = (wp-rp)==16; no write ever occurs when full.
REQ-030 inSync=1 in WAIT, FILL, DISCARD.

Reset
REQ-031 rst: state=HUNT, idx=0, wp=cp=rp=0, width=cfgWidth, FrValid=0, FrLast=0, FrWord=0, inSync=0, frameCount=0, dropCount=0.
REQ-032 rst mid-frame discards all buffered and committed data; buffer contents need not be cleared.
REQ-033 rst overrides every other input in the same cycle.

Configuration
REQ-034 Macro TRACE_FRAME_STATS_EN defined: frameCount/dropCount implemented, +1 per event, saturate at 16'hFFFF; undefined: both outputs constant 0, no counter registers.

Verification
REQ-035 Reset, sync=1, PacketReset, 8 words 0x0100..0x0807, FrReady=1 -> FrValid rises cycle after 8th word, 8 words out in order, FrLast only on 0x0807, frameCount=1.
REQ-036 FrReady=0, 3 full frames after PacketReset -> frames 1-2 buffered, frame 3 discarded, dropCount=1; FrReady=1 -> exactly 16 words out, frame 1 then 2.
REQ-037 5 words then PacketReset then 8 words 0xA000..0xA007 -> only the 0xA0xx words emerge; frameCount=1.
REQ-038 4 words then sync=0 -> inSync=0 next cycle, FrValid stays 0; cfgWidth=2 while in HUNT -> width=2; cfgWidth=1 while in FILL -> width stays 2.
REQ-039 WdAvail and PacketReset in the same cycle -> word dropped, next word stored as idx 0.
REQ-040 With FrReady=1 throughout, frame 2 commits while frame 1 is popping -> no word lost or duplicated, rp/cp wrap past 16 correctly.
